// File: rtl/ball_motion_ctrl.sv
// ball_motion_ctrl
// Moves a square ball across a VGA playfield from two tilt inputs. Position
// updates happen once per motion tick (every TICK_DIV clocks). Each axis moves
// independently, saturates at the playfield edges and can be blocked per
// direction by per-portion maze collision flags. A registered sprite lookup
// reports whether the current VGA pixel lies inside the ball, and if so which
// sprite ROM word it maps to.
//
// Optional feature macro: BALL_GOAL_DETECT_EN
//   defined   : entering the goal window starts a HOLD_TICKS celebration
//               (goal high, position frozen), counts the goal, then respawns
//               at (RESTART_X, RESTART_Y).
//   undefined : no GOAL state; goal and goal_count are tied to 0 and the ball
//               passes freely through the goal window.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   x_axis, y_axis         signed tilt; negative = left / up
//   stop_*_portions        per-portion collision flags, any bit blocks that direction
//   hcounter, vcounter     current VGA pixel coordinates
//   x_ball, y_ball         top-left ball position
//   ball_en, ball_addr     registered sprite hit flag and sprite ROM address
//   goal, goal_count       celebration flag and saturating goal count
//   fsm_state              current FSM state (SPAWN=0, PLAY=1, GOAL=2)
module ball_motion_ctrl #(
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 480,
  parameter int BALL_WIDTH = 8,
  parameter int N_PORTIONS = 6,
  parameter int TICK_DIV   = 1024,
  parameter int AXIS_SHIFT = 5,
  parameter int MAX_STEP   = 4,
  parameter int DEADZONE   = 8,
  parameter int START_X    = 40,
  parameter int START_Y    = 0,
  parameter int RESTART_X  = 100,
  parameter int RESTART_Y  = 0,
  parameter int GOAL_X_MIN = 575,
  parameter int GOAL_X_MAX = 590,
  parameter int GOAL_Y_MIN = 450,
  parameter int GOAL_Y_MAX = 500,
  parameter int HOLD_TICKS = 60,
  localparam int AW = $clog2(BALL_WIDTH * BALL_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [9:0]            x_axis,
  input  logic [9:0]            y_axis,
  input  logic [N_PORTIONS-1:0] stop_right_portions,
  input  logic [N_PORTIONS-1:0] stop_left_portions,
  input  logic [N_PORTIONS-1:0] stop_up_portions,
  input  logic [N_PORTIONS-1:0] stop_down_portions,
  input  logic [10:0]           hcounter,
  input  logic [10:0]           vcounter,
  output logic [10:0]           x_ball,
  output logic [10:0]           y_ball,
  output logic                  ball_en,
  output logic [AW-1:0]         ball_addr,
  output logic                  goal,
  output logic [7:0]            goal_count,
  output logic [1:0]            fsm_state
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [10:0] X_MAX    = 11'(SCREEN_W - BALL_WIDTH);
  localparam logic [10:0] Y_MAX    = 11'(SCREEN_H - BALL_WIDTH);
  localparam logic [9:0]  DZ       = 10'(DEADZONE);
  localparam logic [10:0] STEP_MAX = 11'(MAX_STEP);

`ifdef BALL_GOAL_DETECT_EN
  typedef enum logic [1:0] {SPAWN = 2'd0, PLAY = 2'd1, GOAL = 2'd2} state_t;
  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
`else
  typedef enum logic [1:0] {SPAWN = 2'd0, PLAY = 2'd1} state_t;
`endif

  // 10-bit magnitude: -512 maps to 512, which still fits unsigned.
  function automatic logic [10:0] calc_step(input logic [9:0] tilt);
    logic [9:0] mag;
    logic [9:0] sh;
    mag = tilt[9] ? (~tilt + 10'd1) : tilt;
    sh  = mag >> AXIS_SHIFT;
    if (mag < DZ)                 return 11'd0;
    else if ({1'b0, sh} > STEP_MAX) return STEP_MAX;
    else                          return {1'b0, sh};
  endfunction

  // Saturating move; a blocked direction leaves the position untouched.
  function automatic logic [10:0] move(input logic [10:0] pos, input logic [10:0] step,
                                       input logic neg, input logic blocked,
                                       input logic [10:0] lim);
    logic [11:0] sum;
    sum = {1'b0, pos} + {1'b0, step};
    if (blocked)          return pos;
    else if (neg)         return (pos < step) ? 11'd0 : pos - step;
    else if (sum > {1'b0, lim}) return lim;
    else                  return sum[10:0];
  endfunction

  state_t          state, state_next;
  logic [CW-1:0]   tick_cnt;
  logic            tick;
  logic            x_block, y_block;
  logic [10:0]     x_mv, y_mv, x_d, y_d;
  logic            hit;
  logic [10:0]     dx, dy;
  logic [AW-1:0]   addr_d;

  assign tick      = (tick_cnt == TICK_LAST);
  assign fsm_state = state;

  assign x_block = x_axis[9] ? (|stop_left_portions) : (|stop_right_portions);
  assign y_block = y_axis[9] ? (|stop_up_portions)   : (|stop_down_portions);
  assign x_mv    = move(x_ball, calc_step(x_axis), x_axis[9], x_block, X_MAX);
  assign y_mv    = move(y_ball, calc_step(y_axis), y_axis[9], y_block, Y_MAX);

`ifdef BALL_GOAL_DETECT_EN
  logic [HW-1:0] hold_cnt, hold_d;
  logic [7:0]    count_r, count_d;
  logic          in_goal;

  assign in_goal = (x_mv > 11'(GOAL_X_MIN)) && (x_mv < 11'(GOAL_X_MAX)) &&
                   (y_mv > 11'(GOAL_Y_MIN)) && (y_mv < 11'(GOAL_Y_MAX));
  assign goal       = (state == GOAL);
  assign goal_count = count_r;
`else
  assign goal       = 1'b0;
  assign goal_count = 8'd0;
`endif

  always_comb begin
    state_next = state;
    x_d        = x_ball;
    y_d        = y_ball;
`ifdef BALL_GOAL_DETECT_EN
    hold_d     = hold_cnt;
    count_d    = count_r;
`endif
    case (state)
      SPAWN: begin
        x_d        = 11'(START_X);
        y_d        = 11'(START_Y);
        state_next = PLAY;
      end
      PLAY: begin
        if (tick) begin
          x_d = x_mv;
          y_d = y_mv;
`ifdef BALL_GOAL_DETECT_EN
          if (in_goal) begin
            state_next = GOAL;
            hold_d     = '0;
            if (count_r != 8'hFF) count_d = count_r + 8'd1;
          end
`endif
        end
      end
`ifdef BALL_GOAL_DETECT_EN
      // Position stays frozen until the last celebration tick respawns it.
      GOAL: begin
        if (tick) begin
          if (hold_cnt == HOLD_LAST) begin
            x_d        = 11'(RESTART_X);
            y_d        = 11'(RESTART_Y);
            state_next = PLAY;
          end else begin
            hold_d = hold_cnt + 1'b1;
          end
        end
      end
`endif
      default: state_next = SPAWN;
    endcase
  end

  // Sprite hit window is (x, x+BALL_WIDTH] horizontally and likewise vertically.
  assign hit = ({1'b0, hcounter} > {1'b0, x_ball}) &&
               ({1'b0, hcounter} <= {1'b0, x_ball} + 12'(BALL_WIDTH)) &&
               ({1'b0, vcounter} > {1'b0, y_ball}) &&
               ({1'b0, vcounter} <= {1'b0, y_ball} + 12'(BALL_WIDTH));
  assign dx     = hcounter - x_ball - 11'd1;
  assign dy     = vcounter - y_ball - 11'd1;
  assign addr_d = AW'(BALL_WIDTH) * AW'(dy) + AW'(dx);

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt  <= '0;
      state     <= SPAWN;
      x_ball    <= 11'(START_X);
      y_ball    <= 11'(START_Y);
      ball_en   <= 1'b0;
      ball_addr <= '0;
`ifdef BALL_GOAL_DETECT_EN
      hold_cnt  <= '0;
      count_r   <= 8'd0;
`endif
    end else begin
      tick_cnt  <= tick ? '0 : tick_cnt + 1'b1;
      state     <= state_next;
      x_ball    <= x_d;
      y_ball    <= y_d;
      ball_en   <= hit;
      ball_addr <= hit ? addr_d : '0;
`ifdef BALL_GOAL_DETECT_EN
      hold_cnt  <= hold_d;
      count_r   <= count_d;
`endif
    end
  end

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Testbench for ball_motion_ctrl with TICK_DIV=4. Tilt/stop stimulus is
// applied per motion tick; a small behavioural model produces the expected
// position/goal state, which is queued when stimulus is driven and compared
// once the tick has happened. Goal behaviour is exercised when
// BALL_GOAL_DETECT_EN is defined; otherwise free passage through the goal
// window and the tied-off goal outputs are checked.
module tb_ball_motion_ctrl;

  localparam int W = 31;  // {goal, goal_count[7:0], x[10:0], y[10:0]}

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  x_axis, y_axis;
  logic [5:0]  stop_right_portions, stop_left_portions;
  logic [5:0]  stop_up_portions, stop_down_portions;
  logic [10:0] hcounter, vcounter;
  logic [10:0] x_ball, y_ball;
  logic        ball_en;
  logic [5:0]  ball_addr;
  logic        goal;
  logic [7:0]  goal_count;
  logic [1:0]  fsm_state;

  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  ball_motion_ctrl #(.TICK_DIV(4)) dut (
    .clk(clk), .rst(rst),
    .x_axis(x_axis), .y_axis(y_axis),
    .stop_right_portions(stop_right_portions),
    .stop_left_portions(stop_left_portions),
    .stop_up_portions(stop_up_portions),
    .stop_down_portions(stop_down_portions),
    .hcounter(hcounter), .vcounter(vcounter),
    .x_ball(x_ball), .y_ball(y_ball),
    .ball_en(ball_en), .ball_addr(ball_addr),
    .goal(goal), .goal_count(goal_count),
    .fsm_state(fsm_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];
  logic [6:0]   spr_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int mx, my, mcount, mhold;
  bit mgoal;
  int xa, ya;

  function automatic int step_of(input int tilt);
    int mag;
    int s;
    mag = (tilt < 0) ? -tilt : tilt;
    if (mag < 8) return 0;
    s = mag >> 5;
    return (s > 4) ? 4 : s;
  endfunction

  task automatic model_tick();
    int sx, sy;
    if (mgoal) begin
      mhold++;
      if (mhold == 60) begin
        mgoal = 0;
        mx = 100;
        my = 0;
      end
    end else begin
      sx = step_of(xa);
      sy = step_of(ya);
      if (xa < 0 && stop_left_portions == 0)  mx = (mx - sx < 0) ? 0 : mx - sx;
      if (xa > 0 && stop_right_portions == 0) mx = (mx + sx > 632) ? 632 : mx + sx;
      if (ya < 0 && stop_up_portions == 0)    my = (my - sy < 0) ? 0 : my - sy;
      if (ya > 0 && stop_down_portions == 0)  my = (my + sy > 472) ? 472 : my + sy;
`ifdef BALL_GOAL_DETECT_EN
      if (mx > 575 && mx < 590 && my > 450 && my < 500) begin
        mgoal  = 1;
        mhold  = 0;
        mcount = (mcount == 255) ? 255 : mcount + 1;
      end
`endif
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance to the negedge just after the next motion-tick edge.
  task automatic next_tick();
    do @(negedge clk); while (cyc % 4 != 0);
  endtask

  task automatic drive_tick(input int xi, input int yi);
    logic [W-1:0] e;
    xa = xi;
    ya = yi;
    x_axis = 10'(xi);
    y_axis = 10'(yi);
    model_tick();
    exp_q.push_back({mgoal, 8'(mcount), 11'(mx), 11'(my)});
    next_tick();
    e = exp_q.pop_front();
    check_val("x_ball", x_ball, e[21:11]);
    check_val("y_ball", y_ball, e[10:0]);
    check_val("goal", goal, e[30]);
    check_val("goal_count", goal_count, e[29:22]);
  endtask

  task automatic spr_check(input int h, input int v, input bit en, input int addr);
    logic [6:0] s;
    hcounter = 11'(h);
    vcounter = 11'(v);
    spr_q.push_back({en, 6'(addr)});
    @(negedge clk);
    s = spr_q.pop_front();
    check_val("ball_en", ball_en, s[6]);
    check_val("ball_addr", ball_addr, s[5:0]);
  endtask

  task automatic reset_mid_cycle();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_val("rst_goal", goal, 0);
    check_val("rst_goal_count", goal_count, 0);
    check_val("rst_x", x_ball, 40);
    check_val("rst_y", y_ball, 0);
    check_val("rst_state", fsm_state, 0);
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    x_axis = 10'd100; y_axis = 10'd0; xa = 100; ya = 0;
    stop_right_portions = '0; stop_left_portions = '0;
    stop_up_portions = '0; stop_down_portions = '0;
    hcounter = '0; vcounter = '0;
    repeat (3) @(negedge clk);

    check_val("reset_x", x_ball, 40);
    check_val("reset_y", y_ball, 0);
    check_val("reset_en", ball_en, 0);
    check_val("reset_addr", ball_addr, 0);
    check_val("reset_goal", goal, 0);
    check_val("reset_goal_count", goal_count, 0);
    check_val("reset_state", fsm_state, 0);

    mx = 40; my = 0; mcount = 0; mhold = 0; mgoal = 0;
    rst = 1'b0;
    @(negedge clk);
    check_val("spawn_x", x_ball, 40);
    check_val("play_state", fsm_state, 1);

    // +100 tilt: step 3 per tick
    drive_tick(100, 0);
    drive_tick(100, 0);

    // full left tilt, y inside dead zone: saturate at 0
    for (int i = 0; i < 14; i++) drive_tick(-512, 5);

    // right blocked by one portion, then released
    stop_right_portions[3] = 1'b1;
    for (int i = 0; i < 3; i++) drive_tick(200, 0);
    stop_right_portions[3] = 1'b0;
    drive_tick(200, 0);
    drive_tick(200, 0);

    // per-direction blocking on the other directions
    stop_down_portions[0] = 1'b1;
    drive_tick(200, 200);
    stop_down_portions[0] = 1'b0;
    drive_tick(200, 200);
    stop_up_portions[5] = 1'b1;
    drive_tick(200, -200);
    stop_up_portions[5] = 1'b0;
    drive_tick(200, -200);
    stop_left_portions[0] = 1'b1;
    drive_tick(-200, 0);
    stop_left_portions[0] = 1'b0;
    drive_tick(-40, -40);
    drive_tick(7, 0);

    // run to the right edge along y=0 (through goal x-range, outside y-range)
    for (int i = 0; i < 200 && mx < 632; i++) drive_tick(511, 0);
    drive_tick(511, 0);
    drive_tick(0, 0);

    // sprite lookup at the right edge
    spr_check(mx + 1, my + 2, 1'b1, 8);
    spr_check(mx + 8, my + 8, 1'b1, 63);
    spr_check(mx + 5, my + 4, 1'b1, 28);
    spr_check(mx,     my + 1, 1'b0, 0);
    spr_check(mx + 9, my + 1, 1'b0, 0);
    spr_check(mx + 1, my + 9, 1'b0, 0);

    // line up with the goal window in x
    for (int i = 0; i < 40 && mx > 580; i++) drive_tick(-512, 0);

`ifdef BALL_GOAL_DETECT_EN
    for (int i = 0; i < 200 && !mgoal; i++) drive_tick(0, 200);
    check_val("goal_entered", goal, 1);
    for (int i = 0; i < 60; i++) drive_tick(0, 200);
    check_val("restart_x", x_ball, 100);
    drive_tick(0, 200);
    for (int i = 0; i < 250 && !mgoal; i++) drive_tick(200, 200);
    check_val("goal_count_two", goal_count, 2);
    check_val("goal_state", fsm_state, 2);
    for (int i = 0; i < 5; i++) drive_tick(200, 200);
`else
    for (int i = 0; i < 200 && my < 472; i++) drive_tick(0, 200);
    drive_tick(0, 200);
    drive_tick(0, 200);
`endif
    reset_mid_cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
